// File: rtl/pe_seq_ctrl.sv
// Job sequencer for one PE MAC/round datapath: streams operand pairs into interleaved
// accumulator slots, drains the multiplier pipeline, then rounds and streams out one result per slot.
module pe_seq_ctrl #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_SLOTS = 8,
    parameter int unsigned LEN_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic [3:0]        cfg_slots_i,
    input  logic [2:0]        cfg_conn_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [DATA_W-1:0] a_data1_i,
    input  logic [DATA_W-1:0] a_data2_i,
    output logic [DATA_W-1:0] pe_data_in_1_o,
    output logic [DATA_W-1:0] pe_data_in_2_o,
    output logic [3:0]        pe_add_number_o,
    output logic              pe_acc_clr_o,
    output logic [3:0]        pe_round_number_o,
    output logic              pe_rounder_en_o,
    output logic [2:0]        pe_connection_state_o,
    input  logic [DATA_W-1:0] pe_data_out_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [3:0]        out_slot_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StRound,
        StOut,
        StDone
    } state_e;

    localparam logic [3:0]       MaxSlots = 4'(NUM_SLOTS);
    localparam logic [LEN_W-1:0] LenOne   = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] pass_q, pass_d;
    logic [3:0]       slots_q, slots_d;
    logic [3:0]       slot_q, slot_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [3:0]       add_num_q, add_num_d;
    logic [2:0]       conn_q, conn_d;
    logic             drain_q, drain_d;
    logic             acc_clr_q, acc_clr_d;

    logic [LEN_W-1:0] len_clamp;
    logic [3:0]       slots_clamp;
    logic             run_st;
    logic             hs;
    logic             slot_last;
    logic             hs_last;
    logic             rnd_last;
    logic             rnd_active;
    logic             out_st;

    always_comb begin
        len_clamp   = (cfg_len_i == '0) ? LenOne : cfg_len_i;
        slots_clamp = cfg_slots_i;
        if (cfg_slots_i == 4'd0) begin
            slots_clamp = 4'd1;
        end else if (cfg_slots_i > MaxSlots) begin
            slots_clamp = MaxSlots;
        end
    end

    assign run_st     = (state_q == StRun);
    assign hs         = run_st & a_valid_i;
    assign slot_last  = (slot_q == slots_q - 4'd1);
    assign hs_last    = hs & slot_last & (pass_q == len_q - LenOne);
    assign rnd_last   = (rnd_q == slots_q - 4'd1);
    assign rnd_active = (state_q == StRound) || (state_q == StOut);
    assign out_st     = (state_q == StOut);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pass_d    = pass_q;
        slots_d   = slots_q;
        slot_d    = slot_q;
        rnd_d     = rnd_q;
        conn_d    = conn_q;
        drain_d   = drain_q;
        // The slot index of a write trails its operand handshake by one cycle.
        add_num_d = hs ? slot_q : add_num_q;
        acc_clr_d = hs && (pass_q == '0);

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d   = len_clamp;
                    slots_d = slots_clamp;
                    conn_d  = cfg_conn_i;
                    slot_d  = 4'd0;
                    pass_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (hs_last) begin
                    drain_d = 1'b0;
                    state_d = StDrain;
                end else if (hs) begin
                    if (slot_last) begin
                        slot_d = 4'd0;
                        pass_d = pass_q + LenOne;
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end
            end
            StDrain: begin
                if (drain_q) begin
                    rnd_d   = 4'd0;
                    state_d = StRound;
                end else begin
                    drain_d = 1'b1;
                end
            end
            StRound: begin
                state_d = StOut;
            end
            StOut: begin
                if (out_ready_i) begin
                    if (rnd_last) begin
                        state_d = StDone;
                    end else begin
                        rnd_d   = rnd_q + 4'd1;
                        state_d = StRound;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            len_q     <= '0;
            pass_q    <= '0;
            slots_q   <= 4'd0;
            slot_q    <= 4'd0;
            rnd_q     <= 4'd0;
            conn_q    <= 3'd0;
            drain_q   <= 1'b0;
            add_num_q <= 4'd0;
            acc_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            pass_q    <= pass_d;
            slots_q   <= slots_d;
            slot_q    <= slot_d;
            rnd_q     <= rnd_d;
            conn_q    <= conn_d;
            drain_q   <= drain_d;
            add_num_q <= add_num_d;
            acc_clr_q <= acc_clr_d;
        end
    end

    // Operands are zeroed outside a handshake so stray products add nothing.
    always_comb begin
        busy_o                = (state_q != StIdle);
        done_o                = (state_q == StDone);
        a_ready_o             = run_st;
        pe_data_in_1_o        = hs ? a_data1_i : '0;
        pe_data_in_2_o        = hs ? a_data2_i : '0;
        pe_add_number_o       = add_num_q;
        pe_acc_clr_o          = acc_clr_q;
        pe_rounder_en_o       = rnd_active;
        pe_round_number_o     = rnd_active ? rnd_q : 4'd0;
        pe_connection_state_o = conn_q;
        out_valid_o           = out_st;
        out_data_o            = out_st ? pe_data_out_i : '0;
        out_slot_o            = out_st ? rnd_q : 4'd0;
    end

endmodule
